ping_pong_display: RTL and testbench

PING_PONG_DISPLAY -- requirements
Module: ping_pong_display

---
 rtl/ppd_pkg.sv | 22 ++
 rtl/ppd_seg_decoder.sv | 12 +
 rtl/ping_pong_display.sv | 63 ++++++
 tb/tb_ping_pong_display.sv | 126 ++++++++++++
 4 files changed

// File: rtl/ppd_pkg.sv
// ppd_pkg: segment glyphs, digit codes and anode table shared by the ping-pong display.
package ppd_pkg;
  typedef logic [1:0] digit_idx_t;
  localparam logic [3:0] D_UP = 4'd10;
  localparam logic [3:0] D_DOWN = 4'd11;
  localparam logic [3:0] D_BLANK = 4'd15;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] GLYPH_UP = 7'b1011100;
  localparam logic [6:0] GLYPH_DOWN = 7'b1100011;
  localparam logic [3:0] AN_OFF = 4'b1111;
  localparam logic [3:0][3:0] AN_TABLE = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
endpackage

// File: rtl/ppd_seg_decoder.sv
// ppd_seg_decoder: 4-bit digit code to active-low segments (10=up, 11=down, 12-15=blank).
module ppd_seg_decoder
  import ppd_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);
  localparam logic [15:0][6:0] SEG_LUT = {SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK,
                                          GLYPH_DOWN, GLYPH_UP, SEG_9, SEG_8, SEG_7, SEG_6,
                                          SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};
  assign o_seg = SEG_LUT[i_digit];
endmodule

// File: rtl/ping_pong_display.sv
// ping_pong_display: 4-digit multiplexed display of a ping-pong counter value and direction.
// Define PPD_LEADING_ZERO_BLANK_EN to blank the tens digit for values below 10.
module ping_pong_display
  import ppd_pkg::*;
#(
  parameter logic [15:0] SCAN_DIV = 16'd50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] value,
  input  logic       direction,
  input  logic       hold,
  output logic [3:0] an,
  output logic [6:0] seg
);
  localparam logic [15:0] LAST = SCAN_DIV - 16'd1;
  logic [15:0] r_cnt;
  digit_idx_t  r_idx;
  logic [3:0]  r_val;
  logic        r_dir;
  logic [3:0]  r_an;
  logic [6:0]  r_seg;
  logic        w_tick;
  logic        w_ge10;
  logic [3:0]  w_ones;
  logic [3:0]  w_tens;
  logic [3:0]  w_digit;
  logic [6:0]  w_seg;
  always_comb begin
    w_tick = r_cnt == LAST;
    w_ge10 = r_val >= 4'd10;
    w_ones = w_ge10 ? r_val - 4'd10 : r_val;
`ifdef PPD_LEADING_ZERO_BLANK_EN
    w_tens = w_ge10 ? 4'd1 : D_BLANK;
`else
    w_tens = w_ge10 ? 4'd1 : 4'd0;
`endif
    w_digit = r_idx == 2'd0 ? w_ones : r_idx == 2'd1 ? w_tens : r_dir ? D_UP : D_DOWN;
  end
  ppd_seg_decoder u_dec (
    .i_digit(w_digit),
    .o_seg  (w_seg)
  );
  // Snapshot only on the 3->0 wrap so every frame shows one consistent value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_val <= 4'd0;
      r_dir <= 1'b1;
      r_an  <= AN_OFF;
      r_seg <= SEG_BLANK;
    end else begin
      r_cnt <= w_tick ? 16'd0 : r_cnt + 16'd1;
      if (w_tick) r_idx <= r_idx + 2'd1;
      if (w_tick && r_idx == 2'd3 && !hold) {r_val, r_dir} <= {value, direction};
      r_an  <= AN_TABLE[r_idx];
      r_seg <= w_seg;
    end
  end
  assign an  = r_an;
  assign seg = r_seg;
endmodule

// File: tb/tb_ping_pong_display.sv
// tb_ping_pong_display: scoreboard bench, SCAN_DIV=4 main instance plus SCAN_DIV=1 reset instance.
module tb_ping_pong_display;
  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100, G3 = 7'b0110000;
  localparam logic [6:0] G5 = 7'b0010010, G6 = 7'b0000010, G7 = 7'b1111000, G9 = 7'b0010000;
  localparam logic [6:0] BL = 7'b1111111, UP = 7'b1011100, DN = 7'b1100011;
`ifdef PPD_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] T0 = BL;
`else
  localparam logic [6:0] T0 = G0;
`endif
  typedef struct {
    int         cyc;
    bit         sel;
    logic [3:0] an;
    logic [6:0] seg;
    string      name;
  } exp_t;
  exp_t q[$];
  logic clk = 1'b0;
  logic rst_n, rst1_n, direction, hold;
  logic [3:0] value, an, an1;
  logic [6:0] seg, seg1;
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  ping_pong_display #(.SCAN_DIV(16'd4)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .direction(direction), .hold(hold), .an(an), .seg(seg)
  );
  ping_pong_display #(.SCAN_DIV(16'd1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .value(value), .direction(direction), .hold(hold), .an(an1), .seg(seg1)
  );
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == cyc) begin
        logic [3:0] a;
        logic [6:0] s;
        a = q[i].sel ? an1 : an;
        s = q[i].sel ? seg1 : seg;
        vectors++;
        if (a !== q[i].an || s !== q[i].seg) begin
          miscompares++;
          $display("FAIL %s cyc=%0d got an=%b seg=%b, expected an=%b seg=%b",
                   q[i].name, cyc, a, s, q[i].an, q[i].seg);
        end
        q.delete(i);
      end
    end
  end
  task automatic at(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic push(input int c, input bit sel, input logic [3:0] a, input logic [6:0] s,
                      input string name);
    exp_t e;
    e.cyc = c; e.sel = sel; e.an = a; e.seg = s; e.name = name;
    q.push_back(e);
  endtask
  task automatic frame(input int base, input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] sd, input string name);
    logic [3:0] a;
    for (int k = 0; k < 16; k++) begin
      a = k < 4 ? 4'b1110 : k < 8 ? 4'b1101 : k < 12 ? 4'b1011 : 4'b0111;
      push(base + k, 1'b0, a, k < 4 ? s0 : k < 8 ? s1 : sd, name);
    end
  endtask
  initial begin
    rst_n = 1'b0; rst1_n = 1'b0; value = 4'd0; direction = 1'b1; hold = 1'b0;
    at(3);
    push(3, 1'b0, 4'b1111, BL, "reset_main");
    push(3, 1'b1, 4'b1111, BL, "reset_div1");
    rst_n = 1'b1; rst1_n = 1'b1; value = 4'd13; direction = 1'b0;
    frame(4, G0, T0, UP, "frame0_reset_snapshot");
    frame(20, G3, G1, DN, "frame1_13_down");
    at(27);
    value = 4'd5; direction = 1'b1;
    frame(36, G5, T0, UP, "frame2_5_up");
    at(43);
    value = 4'd6;
    frame(52, G6, T0, UP, "frame3_6_after_wrap");
    at(60);
    value = 4'd2;
    frame(68, G2, T0, UP, "frame4_2");
    at(75);
    hold = 1'b1; value = 4'd9;
    frame(84, G2, T0, UP, "frame5_hold");
    frame(100, G2, T0, UP, "frame6_hold");
    at(107);
    hold = 1'b0;
    frame(116, G9, T0, UP, "frame7_9_released");
    at(124);
    value = 4'd7;
    frame(132, G7, T0, UP, "frame8_7_tens");
    at(157);
    rst_n = 1'b0;
    push(158, 1'b0, 4'b1111, BL, "midframe_reset");
    at(158);
    rst_n = 1'b1;
    push(159, 1'b0, 4'b1110, G0, "after_reset_d0");
    push(162, 1'b0, 4'b1110, G0, "after_reset_d0_end");
    push(163, 1'b0, 4'b1101, T0, "after_reset_d1");
    push(168, 1'b1, 4'b1110, G7, "div1_d0");
    push(169, 1'b1, 4'b1101, T0, "div1_d1");
    at(169);
    rst1_n = 1'b0;
    push(170, 1'b1, 4'b1111, BL, "div1_reset_at_idx2");
    at(170);
    rst1_n = 1'b1;
    push(171, 1'b1, 4'b1110, G0, "div1_restart_d0");
    push(172, 1'b1, 4'b1101, T0, "div1_restart_d1");
    push(173, 1'b1, 4'b1011, UP, "div1_restart_d2");
    push(174, 1'b1, 4'b0111, UP, "div1_restart_d3");
    push(175, 1'b1, 4'b1110, G7, "div1_reload_d0");
    at(180);
    if (q.size() != 0) begin
      miscompares += q.size();
      $display("FAIL scoreboard_drain %0d expectations never checked, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
